// File: rtl/fetch_unit.sv
// fetch_unit: owns the program counter and registers the fetched ROM word for Control.
// Taken branches redirect through a small target LUT and cost one bubble cycle.
// A Start/Done handshake frames each program; retired instructions are counted.
module fetch_unit #(
  parameter int PC_W                 = 10,
  parameter int INSTR_W              = 9,
  parameter int LUT_AW               = 5,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF,
  parameter int CNT_W                = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Stall,
  input  logic               Branch,
  input  logic               BranchTaken,
  input  logic [LUT_AW-1:0]  BranchIdx,
  input  logic               LutWe,
  input  logic [LUT_AW-1:0]  LutAddr,
  input  logic [PC_W-1:0]    LutData,
  input  logic [INSTR_W-1:0] InstrIn,
  output logic [PC_W-1:0]    ProgCtr,
  output logic [INSTR_W-1:0] Instr,
  output logic               InstrValid,
  output logic               Done,
  output logic [CNT_W-1:0]   InstrCount
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t            state;
  logic [PC_W-1:0]   lut [2**LUT_AW];

  logic              is_halt;
  logic              is_taken;
  logic [CNT_W-1:0]  cnt_next;

  assign is_halt  = InstrValid && (Instr == HALT_INSTR);
  assign is_taken = InstrValid && Branch && BranchTaken;
  // Saturating increment; callers only use it when the current word is valid.
  assign cnt_next = (InstrCount == {CNT_W{1'b1}}) ? InstrCount : InstrCount + CNT_W'(1);

  // Target LUT: loaded only while no program is running, never reset.
  always_ff @(posedge Clk) begin
    if (LutWe && (state != RUN))
      lut[LutAddr] <= LutData;
  end

  // Control FSM with PC, instruction register, done flag and retire counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      ProgCtr    <= '0;
      Instr      <= '0;
      InstrValid <= 1'b0;
      Done       <= 1'b0;
      InstrCount <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (Start) begin
            state      <= RUN;
            ProgCtr    <= '0;
            InstrValid <= 1'b0;
            InstrCount <= '0;
            Done       <= 1'b0;
          end
        end
        RUN: begin
          // Stall freezes everything, including a branch or halt waiting on Instr.
          if (!Stall) begin
            if (is_halt) begin
              state      <= HALT;
              Done       <= 1'b1;
              InstrValid <= 1'b0;
              InstrCount <= cnt_next;
            end else if (is_taken) begin
              // Redirect and squash the word fetched from the fall-through PC.
              ProgCtr    <= lut[BranchIdx];
              Instr      <= '0;
              InstrValid <= 1'b0;
              InstrCount <= cnt_next;
            end else begin
              ProgCtr    <= ProgCtr + PC_W'(1);
              Instr      <= InstrIn;
              InstrValid <= 1'b1;
              if (InstrValid)
                InstrCount <= cnt_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
